nn_argmax_classifier: RTL

- Downstream stage of the fully connected sigmoid layer. It consumes that layer's N_CLASSES activations as a serial valid/ready stream, one per beat in neuron-index order.
- Produces one classification result per frame: winning class index, winning activation and a frame-error flag.
- Result is held on a valid/ready output until the consumer accepts it. This is the final decision stage of the inference pipeline.

---
 rtl/nn_pkg.sv | 15 +
 rtl/nn_argmax_classifier_if.sv | 43 ++++
 rtl/nn_argmax_classifier.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the inference pipeline: layer-size defaults, index width
// derivation and the argmax FSM state encoding.
package nn_pkg;

    localparam int NN_N_CLASSES = 10;
    localparam int NN_DATA_W    = 16;
    // Narrowest index that still addresses every class (at least one bit).
    localparam int NN_IDX_W     = (NN_N_CLASSES > 1) ? $clog2(NN_N_CLASSES) : 1;

    typedef enum logic {
        COLLECT = 1'b0,
        RESULT  = 1'b1
    } nn_state_e;

endpackage

// File: rtl/nn_argmax_classifier_if.sv
// Activation stream in, classification result out. out_margin exists only when
// NN_ARGMAX_MARGIN_EN is defined.
interface nn_argmax_classifier_if
    import nn_pkg::*;
#(
    parameter int DATA_W = NN_DATA_W,
    parameter int IDX_W  = NN_IDX_W
) ();

    // Both streams use valid/ready: a transfer happens on a rising clock edge
    // where valid && ready; a source holds its payload stable while valid && !ready.
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [IDX_W-1:0]  out_class;
    logic [DATA_W-1:0] out_max;
    logic              out_err;
`ifdef NN_ARGMAX_MARGIN_EN
    logic [DATA_W-1:0] out_margin;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_class, out_max, out_err, out_margin
    );
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_class, out_max, out_err, out_margin
    );
`else
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_class, out_max, out_err
    );
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_class, out_max, out_err
    );
`endif

endinterface

// File: rtl/nn_argmax_classifier.sv
// Per-frame argmax over a serial activation stream with frame-length checking.
// Optional NN_ARGMAX_MARGIN_EN adds a top1-minus-top2 margin output.
module nn_argmax_classifier
    import nn_pkg::*;
#(
    parameter int N_CLASSES = NN_N_CLASSES,
    parameter int DATA_W    = NN_DATA_W,
    parameter int IDX_W     = NN_IDX_W
) (
    input  logic                 clk,
    input  logic                 reset,
    nn_argmax_classifier_if.slave bus,
    output nn_state_e            dbg_state_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);

    nn_state_e         state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic [IDX_W-1:0]  res_class_q, res_class_d;
    logic [DATA_W-1:0] res_max_q, res_max_d;
    logic              res_err_q, res_err_d;
`ifdef NN_ARGMAX_MARGIN_EN
    logic [DATA_W-1:0] second_q, second_d;
    logic [DATA_W-1:0] res_margin_q, res_margin_d;
`endif

    logic in_ready;
    logic out_valid;
    logic beat;
    logic at_last;
    logic frame_end;
    logic frame_err;

    assign beat      = (state_q == COLLECT) && bus.in_valid;
    assign at_last   = (cnt_q == LAST_IDX);
    assign frame_end = beat && (bus.in_last || at_last);
    // A frame is well formed only when in_last lands exactly on the final slot.
    assign frame_err = (bus.in_last != at_last);

    // FSM
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            COLLECT: begin
                in_ready = 1'b1;
                if (frame_end) begin
                    state_d = RESULT;
                end
            end
            RESULT: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: running max/index plus a separate result register so the
    // outputs keep the last verdict while the next frame is being collected.
    always_comb begin
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        max_d       = max_q;
        res_class_d = res_class_q;
        res_max_d   = res_max_q;
        res_err_d   = res_err_q;
`ifdef NN_ARGMAX_MARGIN_EN
        second_d     = second_q;
        res_margin_d = res_margin_q;
`endif
        if (beat) begin
            if (cnt_q == '0) begin
                max_d = bus.in_data;
                idx_d = '0;
`ifdef NN_ARGMAX_MARGIN_EN
                second_d = '0;
`endif
            end else if (bus.in_data > max_q) begin
                max_d = bus.in_data;
                idx_d = cnt_q;
`ifdef NN_ARGMAX_MARGIN_EN
                second_d = max_q;
`endif
            end
`ifdef NN_ARGMAX_MARGIN_EN
            else if (bus.in_data > second_q) begin
                second_d = bus.in_data;
            end
`endif
            if (frame_end) begin
                cnt_d       = '0;
                res_class_d = idx_d;
                res_max_d   = max_d;
                res_err_d   = frame_err;
`ifdef NN_ARGMAX_MARGIN_EN
                res_margin_d = max_d - second_d;
`endif
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            max_q       <= '0;
            res_class_q <= '0;
            res_max_q   <= '0;
            res_err_q   <= 1'b0;
`ifdef NN_ARGMAX_MARGIN_EN
            second_q     <= '0;
            res_margin_q <= '0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            max_q       <= max_d;
            res_class_q <= res_class_d;
            res_max_q   <= res_max_d;
            res_err_q   <= res_err_d;
`ifdef NN_ARGMAX_MARGIN_EN
            second_q     <= second_d;
            res_margin_q <= res_margin_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_class = res_class_q;
    assign bus.out_max   = res_max_q;
    assign bus.out_err   = res_err_q;
`ifdef NN_ARGMAX_MARGIN_EN
    assign bus.out_margin = res_margin_q;
`endif
    assign dbg_state_o = state_q;

endmodule
